// File: rtl/core_lsu.sv
// core_lsu: memory-stage load/store unit.
//
// Turns an ALU effective address plus store data into a single-outstanding,
// word-wide data-bus transaction. It places store data in the correct byte
// lanes and aligns and extends load data. Every accepted request gets exactly
// one response pulse.
//
// Optional feature: define LSU_MISALIGNED_EN to split misaligned half/word
// accesses into two aligned bus transactions. Without it, those accesses
// return err 01 and the bus is not touched. Size 11 is always err 01.
//
// Parameters:
//   MAX_WAIT     bus timeout in cycles counted from mem_req rising, 0 = none
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_*        request from execute stage (valid/ready handshake)
//   resp_*       one-cycle response pulse with load data and error code
//   mem_*        word-wide data bus; mem_req held until mem_ack

module core_lsu #(
  parameter int unsigned MAX_WAIT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUS, SPLIT, RESP} state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WAIT);

  state_t      state, state_nx;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic        split_q;
  logic        second_q;
  logic [31:0] rd_lo_q;
  logic [31:0] wdata_hi_q;
  logic [3:0]  wstrb_hi_q;
  logic [15:0] cnt_q;

  logic        size_bad, misal, split_acc, bad_acc;
  logic [31:0] lane_data;
  logic [3:0]  base_strb;
  logic [7:0]  strb_wide;
  logic [63:0] data_wide;
  logic [63:0] merged;
  logic [31:0] aligned;
  logic        timeout;

  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] r;
    case (size)
      2'b00:   r = uns ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b01:   r = uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign req_ready  = (state == IDLE);
  assign mem_req    = (state == BUS);
  assign resp_valid = (state == RESP);

  // Request decode: alignment check and byte-lane placement of store data.
  // data_wide/strb_wide describe the access across two adjacent words so a
  // split access can take its low and high halves directly.
  always_comb begin
    size_bad  = (req_size == 2'b11);
    misal     = size_bad
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGNED_EN
    split_acc = misal & ~size_bad;
    bad_acc   = size_bad;
`else
    split_acc = 1'b0;
    bad_acc   = misal;
`endif
    case (req_size)
      2'b00:   begin lane_data = {4{req_wdata[7:0]}};  base_strb = 4'b0001; end
      2'b01:   begin lane_data = {2{req_wdata[15:0]}}; base_strb = 4'b0011; end
      default: begin lane_data = req_wdata;            base_strb = 4'b1111; end
    endcase
    strb_wide = {4'b0000, base_strb} << req_addr[1:0];
    data_wide = {32'b0, lane_data} << {req_addr[1:0], 3'b000};
  end

  // Load alignment: a split load shifts across the word pair formed by the
  // first read (held in rd_lo_q) and the second read arriving now.
  always_comb begin
    aligned = mem_rdata >> {off_q, 3'b000};
    merged  = {mem_rdata, rd_lo_q} >> {off_q, 3'b000};
  end

  // The counter is 0 in the first BUS cycle, so comparing cnt+1 against
  // MAX_WAIT drops mem_req after exactly MAX_WAIT cycles.
  assign timeout = (MAX_WAIT != 0) && ((17'({1'b0, cnt_q}) + 17'd1) == MAX_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic. An ack always beats a timeout in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) state_nx = bad_acc ? RESP : BUS;
      end
      BUS: begin
        if (mem_ack) begin
          if (!mem_err && split_q && !second_q) state_nx = SPLIT;
          else                                  state_nx = RESP;
        end else if (timeout) begin
          state_nx = RESP;
        end
      end
      SPLIT:   state_nx = BUS;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture the request, present the bus transaction, and build
  // the response. Bus outputs change only in cycles where mem_req is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      split_q    <= 1'b0;
      second_q   <= 1'b0;
      rd_lo_q    <= 32'b0;
      wdata_hi_q <= 32'b0;
      wstrb_hi_q <= 4'b0;
      cnt_q      <= 16'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'b0;
      mem_wstrb  <= 4'b0;
      mem_wdata  <= 32'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 2'b00;
    end else begin
      cnt_q <= (state == BUS) ? cnt_q + 16'd1 : 16'd0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            off_q    <= req_addr[1:0];
            split_q  <= split_acc;
            second_q <= 1'b0;
            mem_we   <= req_we;
            mem_addr <= {req_addr[31:2], 2'b00};
            if (split_acc) begin
              mem_wdata  <= data_wide[31:0];
              mem_wstrb  <= req_we ? strb_wide[3:0] : 4'b0000;
              wdata_hi_q <= data_wide[63:32];
              wstrb_hi_q <= req_we ? strb_wide[7:4] : 4'b0000;
            end else begin
              mem_wdata  <= lane_data;
              mem_wstrb  <= req_we ? strb_wide[3:0] : 4'b0000;
            end
            if (bad_acc) begin
              resp_err   <= 2'b01;
              resp_rdata <= 32'b0;
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            if (mem_err) begin
              resp_err   <= 2'b10;
              resp_rdata <= 32'b0;
            end else if (split_q && !second_q) begin
              rd_lo_q   <= mem_rdata;
              second_q  <= 1'b1;
              mem_addr  <= mem_addr + 32'd4;
              mem_wdata <= wdata_hi_q;
              mem_wstrb <= wstrb_hi_q;
            end else begin
              resp_err <= 2'b00;
              if (we_q)          resp_rdata <= 32'b0;
              else if (second_q) resp_rdata <= extend_load(merged[31:0], size_q, uns_q);
              else               resp_rdata <= extend_load(aligned, size_q, uns_q);
            end
          end else if (timeout) begin
            resp_err   <= 2'b10;
            resp_rdata <= 32'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
// Testbench for core_lsu, built with MAX_WAIT = 4 so the timeout is short.
// Latency figures count cycles inclusively, from the accept cycle to the
// resp_valid cycle.

module tb_core_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'b0;
  logic        mem_err = 1'b0;

  int total = 0;
  int bad = 0;

  core_lsu #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ackWait;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] expAddr;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    int          expReqCyc;
    logic [31:0] expRdata;
    logic [1:0]  expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ackWait, input logic [31:0] rdata, input logic err,
                              input logic [31:0] expAddr, input logic [3:0] expStrb,
                              input logic [31:0] expWdata, input int expReqCyc,
                              input logic [31:0] expRdata, input logic [1:0] expErr,
                              input int expLat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.ackWait = ackWait; v.rdata = rdata; v.err = err;
    v.expAddr = expAddr; v.expStrb = expStrb; v.expWdata = expWdata;
    v.expReqCyc = expReqCyc; v.expRdata = expRdata; v.expErr = expErr;
    v.expLat = expLat;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Issues one request and plays the bus slave: ack after ackWait stall
  // cycles (never when ackWait < 0), then checks the response.
  task automatic applyStimulus(input int idx, input vec_t v);
    int  waited;
    int  reqCyc;
    int  lat;
    bit  seen;
    bit  done;
    @(negedge clk);
    checkOutput($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0; reqCyc = 0; lat = 0; seen = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      mem_ack = 1'b0; mem_err = 1'b0;
      if (resp_valid) begin
        lat = k + 2;
        done = 1'b1;
        checkOutput($sformatf("v%0d rdata", idx), resp_rdata, v.expRdata);
        checkOutput($sformatf("v%0d err", idx), {30'b0, resp_err}, {30'b0, v.expErr});
        checkOutput($sformatf("v%0d lat", idx), lat, v.expLat);
      end else begin
        if (mem_req) begin
          reqCyc++;
          if (!seen) begin
            seen = 1'b1;
            checkOutput($sformatf("v%0d addr", idx), mem_addr, v.expAddr);
            checkOutput($sformatf("v%0d wstrb", idx), {28'b0, mem_wstrb}, {28'b0, v.expStrb});
            checkOutput($sformatf("v%0d we", idx), {31'b0, mem_we}, {31'b0, v.we});
            if (v.we) checkOutput($sformatf("v%0d wdata", idx), mem_wdata, v.expWdata);
          end
          if (v.ackWait >= 0 && waited == v.ackWait) begin
            mem_ack = 1'b1; mem_rdata = v.rdata; mem_err = v.err;
          end
          waited++;
        end
        @(negedge clk);
      end
    end
    mem_ack = 1'b0; mem_err = 1'b0;
    checkOutput($sformatf("v%0d got_resp", idx), {31'b0, done}, 32'd1);
    checkOutput($sformatf("v%0d req_cycles", idx), reqCyc, v.expReqCyc);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Stimulus table: inputs, bus behaviour, expected bus and response.
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 2, 32'hDEADBEEF, 1'b0,
                      32'h1000, 4'h0, 32'h0, 3, 32'hDEADBEEF, 2'b00, 5));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 0, 32'h80112233, 1'b0,
                      32'h1000, 4'h0, 32'h0, 1, 32'hFFFFFF80, 2'b00, 3));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 0, 32'h80112233, 1'b0,
                      32'h1000, 4'h0, 32'h0, 1, 32'h00000080, 2'b00, 3));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h1002, 32'h0, 0, 32'h80112233, 1'b0,
                      32'h1000, 4'h0, 32'h0, 1, 32'h00008011, 2'b00, 3));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h1002, 32'h0, 0, 32'h80112233, 1'b0,
                      32'h1000, 4'h0, 32'h0, 1, 32'hFFFF8011, 2'b00, 3));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h1001, 32'h0, 0, 32'h00007F00, 1'b0,
                      32'h1000, 4'h0, 32'h0, 1, 32'h0000007F, 2'b00, 3));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h1000, 32'h0, 1, 32'h12348000, 1'b0,
                      32'h1000, 4'h0, 32'h0, 2, 32'hFFFF8000, 2'b00, 4));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000ABCD, 1, 32'hFFFFFFFF, 1'b0,
                      32'h2000, 4'hC, 32'hABCDABCD, 2, 32'h0, 2'b00, 4));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h3001, 32'h123456A5, 0, 32'hFFFFFFFF, 1'b0,
                      32'h3000, 4'h2, 32'hA5A5A5A5, 1, 32'h0, 2'b00, 3));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h4000, 32'hCAFEF00D, 0, 32'h0, 1'b0,
                      32'h4000, 4'hF, 32'hCAFEF00D, 1, 32'h0, 2'b00, 3));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 0, 32'h12345678, 1'b1,
                      32'h5000, 4'h0, 32'h0, 1, 32'h0, 2'b10, 3));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, -1, 32'h0, 1'b0,
                      32'h6000, 4'h0, 32'h0, 4, 32'h0, 2'b10, 6));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h6004, 32'h0, 3, 32'h13579BDF, 1'b0,
                      32'h6004, 4'h0, 32'h0, 4, 32'h13579BDF, 2'b00, 6));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 0, 32'h0, 1'b0,
                      32'h0, 4'h0, 32'h0, 0, 32'h0, 2'b01, 2));
`ifndef LSU_MISALIGNED_EN
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1001, 32'h0, 0, 32'h0, 1'b0,
                      32'h0, 4'h0, 32'h0, 0, 32'h0, 2'b01, 2));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h1003, 32'h1234, 0, 32'h0, 1'b0,
                      32'h0, 4'h0, 32'h0, 0, 32'h0, 2'b01, 2));
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst mem_addr", mem_addr, 32'd0);
    checkOutput("rst mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    checkOutput("rst resp_err", {30'b0, resp_err}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

`ifdef LSU_MISALIGNED_EN
    // Split LW at 0x1001: two aligned reads merged into one word.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h1001;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("split req1", {31'b0, mem_req}, 32'd1);
    checkOutput("split addr1", mem_addr, 32'h1000);
    mem_ack = 1'b1; mem_rdata = 32'h44332211;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("split gap", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    checkOutput("split req2", {31'b0, mem_req}, 32'd1);
    checkOutput("split addr2", mem_addr, 32'h1004);
    mem_ack = 1'b1; mem_rdata = 32'h88776655;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("split resp_valid", {31'b0, resp_valid}, 32'd1);
    checkOutput("split rdata", resp_rdata, 32'h55443322);
    checkOutput("split err", {30'b0, resp_err}, 32'd0);
`endif

    // Reset in the middle of a store's bus phase.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h4008; req_wdata = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midrst busy", {31'b0, mem_req}, 32'd1);
    checkOutput("midrst wstrb_before", {28'b0, mem_wstrb}, 32'hF);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("midrst ready", {31'b0, req_ready}, 32'd1);
    checkOutput("midrst mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("midrst mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    checkOutput("midrst mem_addr", mem_addr, 32'd0);
    checkOutput("midrst mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    checkOutput("midrst no_resp1", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst no_resp2", {31'b0, resp_valid}, 32'd0);
    applyStimulus(100, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
- Load/store unit in the memory stage, directly downstream of the execute-stage ALU.
- Takes the ALU-computed effective address (alu_result) plus store data and the load/store opcode.
- Drives a single-outstanding word-wide data-bus transaction; aligns and extends load data; returns one response per request.
- Multi-cycle: the pipeline stalls on req_ready low.

Parameters:
MAX_WAIT, 256, bus timeout in cycles counted from mem_req rising; 0 disables timeout; range 0..65535.

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  access request from execute stage
req_ready  output  1  LSU can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word; 11 illegal
req_unsigned  input  1  zero-extend loads (LBU/LHU); ignored for stores/words
req_addr  input  32  effective address (ALU output)
req_wdata  input  32  store data (rs2)
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  2  00 ok, 01 misaligned/illegal size, 10 access fault
mem_req  output  1  bus request, held until mem_ack
mem_we  output  1  bus write enable
mem_addr  output  32  word address, bits [1:0] always 0
mem_wstrb  output  4  byte strobes, 0 on reads
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  bus completion (one cycle)
mem_rdata  input  32  read word, valid with mem_ack
mem_err  input  1  bus error, valid with mem_ack

Behaviour:
- Reset (async):
  - State IDLE; mem_req, mem_we, mem_wstrb, resp_valid, resp_err, resp_rdata, mem_addr and mem_wdata all 0; req_ready 1.
  - Any in-flight bus access is abandoned; mem_req drops immediately.
- States:
  - IDLE: req_ready = 1. Accept on req_valid in the same cycle.
  - BUS: req_ready = 0.
  - RESP: req_ready = 0; resp_valid = 1 for exactly this cycle; next state IDLE.
- Accept (cycle N), aligned access:
  - Registers op, addr, data; state BUS at N+1 with mem_req = 1.
  - mem_addr = {addr[31:2], 2'b00}.
- Accept (cycle N), misaligned access:
  - Misaligned = half with addr[0] set, or word with addr[1:0] not 00, or size 11.
  - Goes to RESP at N+1 with err 01; no bus activity.
- Store lanes:
  - Byte: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
  - Half: wdata = {2{h}}, wstrb = 0011 << addr[1:0].
  - Word: wdata unchanged, wstrb = 1111.
- BUS state:
  - Bus outputs stay stable until mem_ack.
  - On mem_ack: capture data/err, drop mem_req next cycle, enter RESP.
  - Minimum latency accept to resp_valid: 3 cycles (ack on first BUS cycle).
- Load extract:
  - word = mem_rdata >> (8 × addr[1:0]); take the low byte/half.
  - Sign- or zero-extend per req_unsigned.
- Errors:
  - mem_err with mem_ack gives err 10, rdata 0.
  - Timeout: counter clears on BUS entry and increments each BUS cycle. On reaching MAX_WAIT without ack, drop mem_req and go to RESP with err 10.
  - mem_ack in the same cycle as timeout: ack wins.
- Responses are unconditionally consumed (no resp_ready). A new req_valid while busy is held by the requester.

Optional Feature:
- Macro: LSU_MISALIGNED_EN.
- Defined — misaligned half/word accesses (size != 11) are split into two aligned bus transactions:
  - First transaction at {addr[31:2],00}, second at that address + 4 (wraps 0xFFFFFFFC → 0x00000000).
  - Store strobes/data are split per word.
  - Load bytes are merged from both reads, then extended.
  - err 10 if either transaction errs or times out; the second is skipped after a first-transaction error.
  - Latency: minimum 5 cycles.
- Not defined: misaligned accesses return err 01 with no bus activity.
- Size 11 always returns err 01.

Test Plan:
- LW at 0x1000, mem_rdata 0xDEADBEEF, ack after 2 wait cycles → mem_addr 0x1000, resp_rdata 0xDEADBEEF, err 00, resp_valid 5 cycles after accept.
- LB 0x1003, mem_rdata 0x80112233 → rdata 0xFFFFFF80; LBU same → 0x00000080; LHU 0x1002 → 0x00008011.
- SH 0x2002, wdata 0x0000ABCD → mem_wdata 0xABCDABCD, mem_wstrb 1100, mem_we 1; resp rdata 0, err 00.
- LW 0x1001 without macro → err 01 one cycle after accept, mem_req never asserted. With macro → reads 0x1000 then 0x1004; 0x44332211/0x88776655 gives rdata 0x55443322.
- MAX_WAIT=4, no ack → mem_req high 4 cycles then low, err 10. Separately, mem_ack+mem_err → err 10. Ack in the timeout cycle → err 00.
- rst asserted mid-BUS → mem_req 0 asynchronously, req_ready 1, no resp_valid. The next LW after release completes normally.
